// File: rtl/disp_pkg.sv
// Shared definitions for the display packet sequencer: register map, packet layout, FSM states.
package disp_pkg;

    localparam logic [3:0] REG_DIGIT0 = 4'h1;
    localparam logic [3:0] REG_DIGIT1 = 4'h2;
    localparam logic [3:0] REG_DIGIT2 = 4'h3;
    localparam logic [3:0] REG_DIGIT3 = 4'h4;
    localparam logic [3:0] REG_DIGIT4 = 4'h5;
    localparam logic [3:0] REG_DIGIT5 = 4'h6;
    localparam logic [3:0] REG_DIGIT6 = 4'h7;
    localparam logic [3:0] REG_DIGIT7 = 4'h8;
    localparam logic [3:0] REG_DECODE = 4'h9;
    localparam logic [3:0] REG_INTENS = 4'hA;
    localparam logic [3:0] REG_SCAN   = 4'hB;
    localparam logic [3:0] REG_SHDN   = 4'hC;
    localparam logic [3:0] REG_TEST   = 4'hF;

    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] addr;
        logic [7:0] data;
    } pkt_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_REFRESH,
        ST_IDLE
    } disp_state_e;

    function automatic pkt_t mk_pkt(input logic [3:0] addr, input logic [7:0] data);
        pkt_t p;
        p.rsvd = 4'h0;
        p.addr = addr;
        p.data = data;
        return p;
    endfunction

endpackage

// File: rtl/disp_seq.sv
// Display packet sequencer: driver init sequence after reset, then digit refresh per BCD reading.
// Optional build macro LZ_BLANK_EN blanks leading-zero digits (data 0x0F) above digit 1.
module disp_seq
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   val,
    input  logic                  val_vld,
    output logic [15:0]           pkt,
    output logic                  vld,
    input  logic                  rdy,
    output logic                  busy
);

    disp_state_e          state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [4*DIGITS-1:0]  snap_q, snap_d;
    logic [4*DIGITS-1:0]  buf_q, buf_d;
    logic                 pend_q, pend_d;
    logic                 last_q, last_d;
    pkt_t                 pkt_q, pkt_d;
    logic                 vld_q, vld_d;
    logic                 busy_q, busy_d;

    logic [3:0] nib [8];
    logic [7:0] blank;
    logic       free;
    pkt_t       init_pkt;
    pkt_t       digit_pkt;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            if (gi < DIGITS) begin : g_used
                assign nib[gi] = snap_q[gi*4 +: 4];
            end else begin : g_unused
                assign nib[gi] = 4'h0;
            end
        end
    endgenerate

`ifdef LZ_BLANK_EN
    // Snapshot is frozen for the whole refresh, so the mask taken from it equals the one at refresh start.
    always_comb begin
        logic run;
        run   = 1'b1;
        blank = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            run      = run & (nib[i] == 4'h0);
            blank[i] = run;
        end
    end
`else
    assign blank = 8'h00;
`endif

    always_comb begin
        case (idx_q)
            3'd0:    init_pkt = mk_pkt(REG_TEST,   8'h00);
            3'd1:    init_pkt = mk_pkt(REG_SCAN,   8'(DIGITS - 1));
            3'd2:    init_pkt = mk_pkt(REG_DECODE, 8'hFF);
            3'd3:    init_pkt = mk_pkt(REG_INTENS, {4'h0, INTENSITY});
            default: init_pkt = mk_pkt(REG_SHDN,   8'h01);
        endcase
    end

    assign digit_pkt = mk_pkt(REG_DIGIT0 + {1'b0, idx_q},
                              blank[idx_q] ? 8'h0F : {4'h0, nib[idx_q]});

    // Output register may be reloaded when empty or when its packet leaves this cycle.
    assign free = !vld_q || rdy;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        vld_d   = vld_q;

        if (val_vld && state_q != ST_IDLE) begin
            buf_d  = val;
            pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (val_vld) begin
                    snap_d  = val;
                    state_d = ST_REFRESH;
                    idx_d   = 3'd0;
                    last_d  = 1'b0;
                end
            end
            ST_INIT: begin
                if (free) begin
                    pkt_d = init_pkt;
                    vld_d = 1'b1;
                    if (idx_q == 3'd4) begin
                        state_d = ST_REFRESH;
                        idx_d   = 3'd0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                if (free && !last_q) begin
                    pkt_d = digit_pkt;
                    vld_d = 1'b1;
                    if (idx_q == 3'(DIGITS - 1)) begin
                        last_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (free) begin
                    // Final digit leaving: restart straight into digit 1 if a newer reading waits.
                    if (pend_d) begin
                        snap_d = buf_d;
                        pend_d = 1'b0;
                        pkt_d  = mk_pkt(REG_DIGIT0, {4'h0, buf_d[3:0]});
                        vld_d  = 1'b1;
                        last_d = (DIGITS == 1);
                        idx_d  = (DIGITS == 1) ? 3'd0 : 3'd1;
                    end else begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = 3'd0;
                    end
                end
            end
        endcase

        busy_d = !(state_d == ST_IDLE && !vld_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= 3'd0;
            snap_q  <= '0;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            pkt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign pkt  = pkt_q;
    assign vld  = vld_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_disp_seq.sv
// Scoreboard bench for disp_seq (DIGITS=4, INTENSITY=8); expectations follow LZ_BLANK_EN when defined.
module tb_disp_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] val;
    logic        val_vld;
    logic [15:0] pkt;
    logic        vld;
    logic        rdy;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int xfer_cnt = 0;
    logic [15:0] exp_q [$];

    disp_seq #(.DIGITS(4), .INTENSITY(4'h8)) dut (
        .clk     (clk),
        .rst     (rst),
        .val     (val),
        .val_vld (val_vld),
        .pkt     (pkt),
        .vld     (vld),
        .rdy     (rdy),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic push4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic push_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0B03);
        exp_q.push_back(16'h09FF);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0C01);
    endtask

    task automatic strobe(input logic [15:0] v);
        val     = v;
        val_vld = 1'b1;
        @(posedge clk);
        #1;
        val_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("xfer_wait", {31'd0, xfer_cnt >= target}, 32'd1);
    endtask

    // Monitor: a vld&rdy seen mid-cycle (rst low) transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && vld === 1'b1 && rdy === 1'b1) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_pkt: got %h expected none", pkt);
            end else begin
                check("pkt_seq", {16'd0, pkt}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] hp;
        int base;
        rst = 1'b1; rdy = 1'b0; val = 16'h0; val_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pkt",  {16'd0, pkt}, 32'h0);
        check("rst_vld",  {31'd0, vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Power-up: init then a zero refresh.
        push_init();
        push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        @(posedge clk); #1;
        rst = 1'b0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("first_vld",  {31'd0, vld}, 32'd1);
        check("first_busy", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_init");

        // Single refresh from IDLE.
        push4(16'h0104, 16'h0203, 16'h0302, 16'h0401);
        strobe(16'h1234);
        @(negedge clk);
        check("busy_after_strobe", {31'd0, busy}, 32'd1);
        wait_idle("idle_after_1234");

        // Backpressure mid-refresh.
        push4(16'h0105, 16'h0206, 16'h0307, 16'h0408);
        base = xfer_cnt;
        strobe(16'h8765);
        wait_xfers(base + 2);
        @(posedge clk); #1;
        rdy = 1'b0;
        @(negedge clk);
        hp = pkt;
        check("hold_vld0", {31'd0, vld}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("hold_pkt", {16'd0, pkt}, {16'd0, hp});
            check("hold_vld", {31'd0, vld}, 32'd1);
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        wait_idle("idle_after_stall");

        // Strobes while busy: only the last pending value is refreshed.
        push4(16'h0104, 16'h0203, 16'h0302, 16'h0401);
        push4(16'h010C, 16'h020B, 16'h030A, 16'h0409);
        strobe(16'h1234);
        strobe(16'h5678);
        strobe(16'h9ABC);
        wait_idle("idle_after_pending");

        // Reset after the third init transfer.
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0B03);
        exp_q.push_back(16'h09FF);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base = xfer_cnt;
        rst = 1'b0;
        wait_xfers(base + 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("vld_in_rst",  {31'd0, vld}, 32'd0);
        check("busy_in_rst", {31'd0, busy}, 32'd0);
        check("q_after_abort", exp_q.size(), 32'd0);
        push_init();
        push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle("idle_after_rerst");

        // Leading-zero handling.
`ifdef LZ_BLANK_EN
        push4(16'h0102, 16'h0204, 16'h030F, 16'h040F);
        strobe(16'h0042);
        wait_idle("idle_after_0042");
        push4(16'h0100, 16'h020F, 16'h030F, 16'h040F);
        strobe(16'h0000);
        wait_idle("idle_after_0000");
`else
        push4(16'h0102, 16'h0204, 16'h0300, 16'h0400);
        strobe(16'h0042);
        wait_idle("idle_after_0042");
        push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        strobe(16'h0000);
        wait_idle("idle_after_0000");
`endif

        repeat (3) @(negedge clk);
        check("q_drained", exp_q.size(), 32'd0);
        check("idle_vld",  {31'd0, vld}, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
